// File: rtl/lcd_pkg.sv
// ============================================================================
// Module : lcd_pkg
// Brief  : Shared HD44780 command/ASCII constants, top FSM state and snapshot
//          type for lcd_status_driver. Optional macro: LCD_OK_LINE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_V     = 8'h56;
  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_M     = 8'h4D;
  localparam logic [7:0] ASC_O     = 8'h4F;
  localparam logic [7:0] ASC_F     = 8'h46;
  localparam logic [7:0] ASC_K     = 8'h4B;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_RESET_WAIT = 2'd0,
    ST_INIT       = 2'd1,
    ST_IDLE       = 2'd2,
    ST_WRITE      = 2'd3
  } lcd_state_e;

  typedef struct packed {
    logic       on;
    logic [1:0] vel;
    logic [2:0] t;
    logic [2:0] m;
`ifdef LCD_OK_LINE_EN
    logic [2:0] ok;
`endif
  } lcd_snap_t;

  function automatic logic [7:0] lcd_digit(input logic [2:0] x);
    return ASC_0 + {5'd0, x};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_byte_writer.sv
// ============================================================================
// Module : lcd_byte_writer
// Brief  : One-byte HD44780 write sequencer: SETUP, PULSE (e high), HOLD.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lcd_byte_writer #(
  parameter int unsigned ENABLE_CYCLES = 12,
  parameter int unsigned SETTLE_CYCLES = 2000,
  parameter int unsigned CLEAR_CYCLES  = 82000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int unsigned MAX_A = (ENABLE_CYCLES > SETTLE_CYCLES) ? ENABLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > CLEAR_CYCLES) ? MAX_A : CLEAR_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {
    BW_IDLE  = 2'd0,
    BW_SETUP = 2'd1,
    BW_PULSE = 2'd2,
    BW_HOLD  = 2'd3
  } bw_state_e;

  bw_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          long_q, long_d;
  logic [CW-1:0] hold_lim;

  assign hold_lim = long_q ? CW'(CLEAR_CYCLES - 1) : CW'(SETTLE_CYCLES - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BW_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    done    = 1'b0;
    case (state_q)
      BW_SETUP: begin
        state_d = BW_PULSE;
        cnt_d   = '0;
      end
      BW_PULSE: begin
        if (cnt_q == CW'(ENABLE_CYCLES - 1)) begin
          state_d = BW_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BW_HOLD: begin
        if (cnt_q == hold_lim) begin
          done    = 1'b1;
          state_d = BW_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // A start in the last HOLD cycle chains straight into the next SETUP.
    if (start) begin
      state_d = BW_SETUP;
      cnt_d   = '0;
      rs_d    = rs_in;
      data_d  = data_in;
      long_d  = long_wait;
    end
  end

  assign lcd_e    = (state_q == BW_PULSE);
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

endmodule

`default_nettype wire

// File: rtl/lcd_status_driver.sv
// ============================================================================
// Module : lcd_status_driver
// Brief  : HD44780 init + line-1 status rewrite on change. Optional macro
//          LCD_OK_LINE_EN adds a line-2 sensor status ("OK:xyz").
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lcd_status_driver
  import lcd_pkg::*;
#(
  parameter int unsigned INIT_CYCLES   = 750000,
  parameter int unsigned ENABLE_CYCLES = 12,
  parameter int unsigned SETTLE_CYCLES = 2000,
  parameter int unsigned CLEAR_CYCLES  = 82000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ON,
  input  logic [1:0] Vel,
  input  logic [2:0] T,
  input  logic [2:0] M,
  input  logic [2:0] Ok,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int unsigned CNT_W       = $clog2(INIT_CYCLES + 1);
  localparam logic [4:0]  INIT_BYTES  = 5'd4;
`ifdef LCD_OK_LINE_EN
  localparam logic [4:0]  WRITE_BYTES = 5'd18;
`else
  localparam logic [4:0]  WRITE_BYTES = 5'd9;
`endif

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  lcd_snap_t        snap_q, snap_d, live;
  logic             invalid_q, invalid_d;
  logic             bw_start, bw_rs, bw_done;
  logic [7:0]       bw_data;

  always_comb begin
    live     = '0;
    live.on  = ON;
    live.vel = Vel;
    live.t   = T;
    live.m   = M;
`ifdef LCD_OK_LINE_EN
    live.ok  = Ok;
`endif
  end

`ifndef LCD_OK_LINE_EN
  logic unused_ok;
  assign unused_ok = ^Ok;
`endif

  function automatic logic [7:0] init_byte(input logic [4:0] idx);
    case (idx)
      5'd1:    return LCD_DISP_ON;
      5'd2:    return LCD_CLEAR;
      5'd3:    return LCD_ENTRY;
      default: return LCD_FUNC_SET;
    endcase
  endfunction

  // Byte idx of a WRITE as {rs, data}; idx 0 (line-1 address) is issued from IDLE.
  function automatic logic [8:0] write_byte(input lcd_snap_t s, input logic [4:0] idx);
    logic [8:0] b;
    b = {1'b1, ASC_SPACE};
    case (idx)
      5'd1:  b[7:0] = s.on ? ASC_V : ASC_O;
      5'd2:  b[7:0] = s.on ? lcd_digit({1'b0, s.vel}) : ASC_F;
      5'd3:  b[7:0] = s.on ? ASC_SPACE : ASC_F;
      5'd4:  b[7:0] = s.on ? ASC_T : ASC_SPACE;
      5'd5:  b[7:0] = s.on ? lcd_digit(s.t) : ASC_SPACE;
      5'd7:  b[7:0] = s.on ? ASC_M : ASC_SPACE;
      5'd8:  b[7:0] = s.on ? lcd_digit(s.m) : ASC_SPACE;
`ifdef LCD_OK_LINE_EN
      5'd9:  b      = {1'b0, LCD_LINE2};
      5'd10: b[7:0] = ASC_O;
      5'd11: b[7:0] = ASC_K;
      5'd12: b[7:0] = ASC_COLON;
      5'd13: b[7:0] = lcd_digit({2'b00, s.ok[2]});
      5'd14: b[7:0] = lcd_digit({2'b00, s.ok[1]});
      5'd15: b[7:0] = lcd_digit({2'b00, s.ok[0]});
`endif
      default: ;
    endcase
    return b;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RESET_WAIT;
      cnt_q     <= '0;
      idx_q     <= 5'd0;
      snap_q    <= '0;
      invalid_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      invalid_q <= invalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    invalid_d = invalid_q;
    bw_start  = 1'b0;
    bw_rs     = 1'b0;
    bw_data   = 8'h00;
    case (state_q)
      ST_RESET_WAIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          cnt_d    = '0;
          state_d  = ST_INIT;
          bw_start = 1'b1;
          bw_data  = LCD_FUNC_SET;
          idx_d    = 5'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (bw_done) begin
          if (idx_q == INIT_BYTES) begin
            state_d   = ST_IDLE;
            invalid_d = 1'b1;
            idx_d     = 5'd0;
          end else begin
            bw_start = 1'b1;
            bw_data  = init_byte(idx_q);
            idx_d    = idx_q + 5'd1;
          end
        end
      end
      ST_IDLE: begin
        if (invalid_q || (live != snap_q)) begin
          snap_d    = live;
          invalid_d = 1'b0;
          bw_start  = 1'b1;
          bw_data   = LCD_LINE1;
          idx_d     = 5'd1;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bw_done) begin
          if (idx_q == WRITE_BYTES) begin
            state_d = ST_IDLE;
            idx_d   = 5'd0;
          end else begin
            bw_start         = 1'b1;
            {bw_rs, bw_data} = write_byte(snap_q, idx_q);
            idx_d            = idx_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  lcd_byte_writer #(
    .ENABLE_CYCLES (ENABLE_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CLEAR_CYCLES  (CLEAR_CYCLES)
  ) u_writer (
    .clock     (clock),
    .reset     (reset),
    .start     (bw_start),
    .rs_in     (bw_rs),
    .data_in   (bw_data),
    .long_wait (!bw_rs && (bw_data == LCD_CLEAR)),
    .done      (bw_done),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  assign lcd_rw = 1'b0;
  assign busy   = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lcd_status_driver.sv
// ============================================================================
// Module : tb_lcd_status_driver
// Brief  : Self-checking bench for lcd_status_driver (honours LCD_OK_LINE_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lcd_status_driver;

  localparam int INIT_C = 20;
  localparam int EN_C   = 2;
  localparam int SET_C  = 5;
  localparam int CLR_C  = 10;
`ifdef LCD_OK_LINE_EN
  localparam int WB = 18;
`else
  localparam int WB = 9;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ON = 1'b1;
  logic [1:0] Vel = 2'd1;
  logic [2:0] T = 3'd1;
  logic [2:0] M = 3'd6;
  logic [2:0] Ok = 3'b101;
  logic       lcd_rs, lcd_rw, lcd_e, busy;
  logic [7:0] lcd_data;

  lcd_status_driver #(
    .INIT_CYCLES   (INIT_C),
    .ENABLE_CYCLES (EN_C),
    .SETTLE_CYCLES (SET_C),
    .CLEAR_CYCLES  (CLR_C)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ON       (ON),
    .Vel      (Vel),
    .T        (T),
    .M        (M),
    .Ok       (Ok),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8:0] b;
    int         cyc;
  } strobe_t;

  strobe_t    cap_q[$];
  int         rise_q[$];
  int         cyc = 0;
  logic       e_prev = 1'b0;
  logic [8:0] held = '0;
  int         stab_err = 0;
  int         busy_low = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor: a byte is taken on each falling edge of e.
  always @(negedge clock) begin
    if (!e_prev && lcd_e) begin
      rise_q.push_back(cyc);
      held <= {lcd_rs, lcd_data};
    end
    if (e_prev && lcd_e && ({lcd_rs, lcd_data} !== held)) stab_err <= stab_err + 1;
    if (e_prev && !lcd_e) cap_q.push_back('{b: {lcd_rs, lcd_data}, cyc: cyc});
    if (!busy) busy_low <= busy_low + 1;
    e_prev <= lcd_e;
  end

  int         n_pass = 0;
  int         n_total = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_busy(input logic val, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (busy === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_caps(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (cap_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic string line1_of(input logic on, input logic [1:0] vel,
                                     input logic [2:0] t, input logic [2:0] m);
    if (on) return $sformatf("V%0d T%0d M%0d", vel, t, m);
    return "OFF     ";
  endfunction

  task automatic build_exp(input string line1);
`ifdef LCD_OK_LINE_EN
    string l2;
`endif
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, line1[i]});
`ifdef LCD_OK_LINE_EN
    l2 = $sformatf("OK:%b%b%b  ", Ok[2], Ok[1], Ok[0]);
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, l2[i]});
`endif
  endtask

  task automatic cmp_caps(input string name, input int base);
    logic [31:0] a;
    chk({name, "_count"}, cap_q.size() - base, exp_q.size());
    foreach (exp_q[i]) begin
      a = (base + i < cap_q.size()) ? 32'(cap_q[base + i].b) : 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", name, i), a, 32'(exp_q[i]));
    end
  endtask

  task automatic apply_vec(input string name, input logic on, input logic [1:0] vel,
                           input logic [2:0] t, input logic [2:0] m, input string line1);
    int base;
    bit ok;
    bit change;
    @(negedge clock);
    change = ({on, vel, t, m} != {ON, Vel, T, M});
    base   = cap_q.size();
    ON = on; Vel = vel; T = t; M = m;
    if (change) begin
      wait_busy(1'b1, 5, ok);
      chk({name, "_start"}, 32'(ok), 1);
      wait_busy(1'b0, 200, ok);
      chk({name, "_done"}, 32'(ok), 1);
      exp_q.delete();
      build_exp(line1);
      cmp_caps(name, base);
    end
    repeat (30) @(negedge clock);
    chk({name, "_quiet"}, cap_q.size() - base, change ? WB : 0);
  endtask

  // Full power-up sequence after a reset release; inputs are already set.
  task automatic check_powerup(input string name, input string line1);
    int  base, rbase, rel, d, last;
    bit  ok;
    @(negedge clock);
    rel   = cyc;
    base  = cap_q.size();
    rbase = rise_q.size();
    reset = 1'b0;
    wait_caps(base + 4 + WB, 800, ok);
    chk({name, "_bytes_seen"}, 32'(ok), 1);
    wait_busy(1'b0, 50, ok);
    chk({name, "_idle"}, 32'(ok), 1);
    last = base + 4 + WB - 1;
    if (last < cap_q.size()) chk({name, "_busy_fall"}, cyc - cap_q[last].cyc, SET_C);
    else chk({name, "_busy_fall_missing"}, 32'(cap_q.size()), 32'(last + 1));
    d = (rbase < rise_q.size()) ? rise_q[rbase] - rel : -1;
    chk({name, "_init_wait"}, 32'(d >= INIT_C + 1 && d <= INIT_C + 2), 1);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    build_exp(line1);
    cmp_caps(name, base);
    for (int i = 1; i < 4 + WB && base + i < cap_q.size(); i++) begin
      if (i != 4)
        chk($sformatf("%s_gap%0d", name, i), cap_q[base + i].cyc - cap_q[base + i - 1].cyc,
            (i == 3) ? (1 + EN_C + CLR_C) : (1 + EN_C + SET_C));
    end
  endtask

  typedef struct {
    logic       on;
    logic [1:0] vel;
    logic [2:0] t;
    logic [2:0] m;
    string      txt;
  } vec_t;

  vec_t vt[5];

  initial begin
    int  base, bl0;
    bit  ok;

    vt[0] = '{on: 1'b1, vel: 2'd3, t: 3'd1, m: 3'd6, txt: "V3 T1 M6"};
    vt[1] = '{on: 1'b0, vel: 2'd3, t: 3'd1, m: 3'd6, txt: "OFF     "};
    vt[2] = '{on: 1'b0, vel: 2'd2, t: 3'd2, m: 3'd2, txt: "OFF     "};
    vt[3] = '{on: 1'b1, vel: 2'd2, t: 3'd4, m: 3'd7, txt: "V2 T4 M7"};
    vt[4] = '{on: 1'b1, vel: 2'd1, t: 3'd3, m: 3'd0, txt: "V1 T3 M0"};

    #12;
    chk("rst_e", 32'(lcd_e), 0);
    chk("rst_rs", 32'(lcd_rs), 0);
    chk("rst_rw", 32'(lcd_rw), 0);
    chk("rst_data", 32'(lcd_data), 0);
    chk("rst_busy", 32'(busy), 1);

    check_powerup("pwr", "V1 T1 M6");

    for (int i = 0; i < 5; i++)
      apply_vec($sformatf("tbl%0d", i), vt[i].on, vt[i].vel, vt[i].t, vt[i].m, vt[i].txt);

    for (int r = 0; r < 6; r++) begin
      logic       on_r;
      logic [1:0] v_r;
      logic [2:0] t_r, m_r;
      do begin
        on_r = 1'($urandom_range(0, 1));
        v_r  = 2'($urandom_range(1, 3));
        t_r  = 3'($urandom_range(1, 4));
        m_r  = 3'($urandom_range(0, 7));
      end while ({on_r, v_r, t_r, m_r} == {ON, Vel, T, M});
      apply_vec($sformatf("rand%0d", r), on_r, v_r, t_r, m_r, line1_of(on_r, v_r, t_r, m_r));
    end

    // Change mid-write: T moves 1->4 while "V3 T1 M6" is being sent.
    apply_vec("off_pre", 1'b0, 2'd3, 3'd4, 3'd5, "OFF     ");
    apply_vec("mid_pre", 1'b1, 2'd1, 3'd1, 3'd6, "V1 T1 M6");
    @(negedge clock);
    base = cap_q.size();
    Vel  = 2'd3;
    wait_caps(base + 3, 100, ok);
    chk("mid_reach_byte3", 32'(ok), 1);
    bl0 = busy_low;
    T   = 3'd4;
    wait_caps(base + 2 * WB, 600, ok);
    chk("mid_two_writes", 32'(ok), 1);
    chk("mid_busy_low_cycles", busy_low - bl0, 1);
    wait_busy(1'b0, 50, ok);
    chk("mid_idle", 32'(ok), 1);
    exp_q.delete();
    build_exp("V3 T1 M6");
    build_exp("V3 T4 M6");
    cmp_caps("mid", base);
    repeat (30) @(negedge clock);
    chk("mid_quiet", cap_q.size() - base, 2 * WB);

    // Reset while e is high.
    @(negedge clock);
    M = 3'd2;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (lcd_e) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstmid_e_high", 32'(ok), 1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_e_async", 32'(lcd_e), 0);
    chk("rstmid_busy", 32'(busy), 1);
    chk("rstmid_data", 32'(lcd_data), 0);
    repeat (2) @(negedge clock);
    check_powerup("rstmid", "V3 T4 M2");

`ifdef LCD_OK_LINE_EN
    @(negedge clock);
    base = cap_q.size();
    Ok   = 3'b001;
    wait_busy(1'b1, 5, ok);
    chk("ok_start", 32'(ok), 1);
    wait_busy(1'b0, 300, ok);
    chk("ok_done", 32'(ok), 1);
    exp_q.delete();
    build_exp("V3 T4 M2");
    cmp_caps("ok", base);
`else
    @(negedge clock);
    base = cap_q.size();
    Ok   = 3'b010;
    repeat (40) @(negedge clock);
    chk("ok_ignored", cap_q.size() - base, 0);
    chk("ok_ignored_busy", 32'(busy), 0);
`endif

    chk("rs_data_stable_while_e", 32'(stab_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lcd_status_driver.md
# lcd_status_driver

Downstream display stage for the air-conditioner controller. Consumes the gated display signals the controller already produces (speed, temperature, mode, on/off) and drives an HD44780-compatible character LCD in 8-bit write-only mode. It runs the power-up initialisation sequence, then rewrites line 1 whenever any displayed value changes.

## Interface
- `INIT_CYCLES`, default 750000: power-up wait before the first command (15 ms at 50 MHz).
- `ENABLE_CYCLES`, default 12: `lcd_e` high time per byte.
- `SETTLE_CYCLES`, default 2000: post-pulse wait for normal bytes (40 µs).
- `CLEAR_CYCLES`, default 82000: post-pulse wait after the clear command 0x01 (1.64 ms).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ON` in 1: controller on/off.
- `Vel` in 2: speed code, 1..3.
- `T` in 3: temperature code, 1..4.
- `M` in 3: mode code.
- `Ok` in 3: sensor status bits. Used only under `LCD_OK_LINE_EN`; the port exists in both builds.
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: constant 0.
- `lcd_e` out 1: enable strobe.
- `lcd_data` out 8: data bus.
- `busy` out 1: high whenever the block is not in IDLE.

## Operation
- Top-level FSM states: RESET_WAIT → INIT → IDLE ⇄ WRITE.
- **RESET_WAIT:** count `INIT_CYCLES`, then go to INIT.
- **INIT:** send, in order, 0x38 (function set), 0x0C (display on, no cursor), 0x01 (clear), 0x06 (entry increment). All are commands (`rs`=0). Then go to IDLE with the "snapshot invalid" flag set.
- **IDLE:** compare {ON,Vel,T,M} with the last-written snapshot. Start WRITE when they differ or the snapshot is invalid:
  - latch the snapshot;
  - clear the invalid flag.
- **WRITE:** send command 0x80 (line 1, column 0), then 8 data bytes built from the latched snapshot only:
  - ON=1: 'V', digit(Vel), ' ', 'T', digit(T), ' ', 'M', digit(M).
  - ON=0: "OFF" followed by 5 spaces.
  - digit(x) = 0x30 + zero-extended x.
  - On the last byte, return to IDLE.
- **Changes during WRITE:** inputs are ignored until IDLE. The IDLE comparison then triggers a fresh write, so no update is lost and there is no pending flag.
- **Byte sequencer**, per byte:
  - SETUP, 1 cycle: `rs`/`data` driven, `e`=0.
  - PULSE: `ENABLE_CYCLES` cycles with `e`=1.
  - HOLD: `SETTLE_CYCLES` cycles, or `CLEAR_CYCLES` for 0x01, with `e`=0 and `rs`/`data` held.
  - It then pulses `done`.

## Timing
- Reset values:
  - `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `busy`=1;
  - snapshot invalid;
  - all counters 0.
- Byte period = 1 + `ENABLE_CYCLES` + settle.
- `rs`/`data` are stable from SETUP through end of HOLD, so they never change while `e`=1.
- First IDLE→WRITE decision happens the cycle after INIT completes. WRITE's first SETUP follows on the next cycle.
- `busy` falls in the cycle IDLE is entered and rises in the cycle WRITE is entered.
- Counters compare with `== N-1` and restart at 0 each phase. No wrap beyond the parameter value.
- Reset asserted mid-operation: `lcd_e` drops to 0 asynchronously and the FSM restarts at RESET_WAIT, including the full init sequence.

## Configuration
- `LCD_OK_LINE_EN` defined: WRITE also sends 0xC0 then 8 data bytes "OK:" followed by `Ok[2]`, `Ok[1]`, `Ok[0]` as '0'/'1', then 2 spaces.
  - `Ok` joins the snapshot and the change comparison.
  - A WRITE is 18 bytes.
- Not defined: `Ok` is ignored, line 2 is never addressed, and a WRITE is 9 bytes.

## Structure
- Shared package `lcd_pkg` holds:
  - command constants: `LCD_FUNC_SET`=0x38, `LCD_DISP_ON`=0x0C, `LCD_CLEAR`=0x01, `LCD_ENTRY`=0x06, `LCD_LINE1`=0x80, `LCD_LINE2`=0xC0;
  - ASCII constants '0', 'V', 'T', 'M', 'O', 'F', 'K', ':', space;
  - the top-level state enum.
- Sub-module `lcd_byte_writer` implements the SETUP/PULSE/HOLD sequencer:
  - inputs `start`, `rs_in`, `data_in`, `long_wait`;
  - output `done`;
  - drives the LCD pins.

## Test plan
Bench parameters: `INIT_CYCLES`=20, `ENABLE_CYCLES`=2, `SETTLE_CYCLES`=5, `CLEAR_CYCLES`=10.

- **Power-up:** release reset with ON=1, Vel=1, T=1, M=6.
  - Captured on `e` falling edge: 0x38, 0x0C, 0x01, 0x06, 0x80 (all `rs`=0), then "V1 T1 M6" (`rs`=1).
  - `busy` falls after the 9th write byte.
  - Gap between the 0x01 and 0x06 strobes is 13 cycles; other gaps are 8.
- **Change detection:** in IDLE, set Vel=3. Exactly one WRITE follows, producing 0x80 then "V3 T1 M6". With inputs held steady afterwards, no further strobes occur.
- **OFF text:** set ON=0 → 0x80 then "OFF" followed by 5 spaces (0x4F, 0x46, 0x46, 0x20 ×5).
- **Change mid-write:** change T 1→4 during the 3rd data byte.
  - The current WRITE completes with T1.
  - `busy` drops for exactly 1 cycle, then a second WRITE shows "T4".
- **Reset mid-pulse:** assert reset while `e`=1.
  - `e`=0 in the same cycle, without waiting for a clock edge.
  - After release, the sequence restarts with the 20-cycle wait and 0x38.
- **`LCD_OK_LINE_EN` build:** Ok=3'b101.
  - WRITE ends with 0xC0, then "OK:101" and 2 spaces.
  - Changing only Ok to 3'b001 triggers a full 18-byte rewrite.
